currentmirror_enable_sequencer: RTL and testbench

- Digital supervisor that drives the enable/test side of a generated currentmirror brick and consumes its `ok_currentmirror` status.
- On request it powers the mirror and waits a settle window. It qualifies `ok_currentmirror` with a debounce, then reports ready.
- It monitors for dropouts, retries with backoff and latches a lockout fault after repeated failures.
- Sits in the regulation loop controller between the loop state machine and each currentmirror instance.

---
 rtl/currentmirror_enable_sequencer_if.sv | 49 ++++
 rtl/currentmirror_enable_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_currentmirror_enable_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/currentmirror_enable_sequencer_if.sv
// Signal bundle between the loop controller / mirror brick and the
// currentmirror enable sequencer.
//
// Signalling semantics: there is no valid/ready transfer on this bundle.
// Every signal is a level that the sequencer samples on each CELCLK
// rising edge. clr_fault is the one pulse: it is honoured only on an
// edge where the sequencer sits in LOCKOUT. ok_currentmirror is
// asynchronous and is synchronised inside the sequencer. All outputs
// change only on CELCLK rising edges.
interface currentmirror_enable_sequencer_if;
  logic       req;
  logic       test_mode;
  logic       clr_fault;
  logic       ok_currentmirror;
  logic       enable_currentmirror;
  logic       ten;
  logic       mirror_ready;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  // Controller / brick side: drives requests and status, observes outputs.
  modport master (
    output req,
    output test_mode,
    output clr_fault,
    output ok_currentmirror,
    input  enable_currentmirror,
    input  ten,
    input  mirror_ready,
    input  fault,
    input  retry_cnt,
    input  state
  );

  // Sequencer side.
  modport slave (
    input  req,
    input  test_mode,
    input  clr_fault,
    input  ok_currentmirror,
    output enable_currentmirror,
    output ten,
    output mirror_ready,
    output fault,
    output retry_cnt,
    output state
  );
endinterface

// File: rtl/currentmirror_enable_sequencer.sv
// Enable sequencer for a generated currentmirror brick.
// Powers the mirror on request, waits a settle window, debounces the
// synchronised ok status, then reports ready. Dropouts in RUN cause a
// retry after a backoff window; repeated failures latch LOCKOUT until
// clr_fault or a withdrawn request. test_mode bypasses qualification.
module currentmirror_enable_sequencer #(
  parameter int SETTLE_CYCLES  = 64,
  parameter int DEBOUNCE       = 4,
  parameter int RETRY_MAX      = 3,
  parameter int BACKOFF_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic                                CELCLK,
  input  logic                                CELRST,
  currentmirror_enable_sequencer_if.slave     bus
);

  localparam int DEB_W = $clog2(DEBOUNCE + 1);

  // Terminal counts: a counter equal to its *_LAST value on an edge
  // means that edge completes the window, so counters never wrap.
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BACKOFF_LAST = CNT_W'(BACKOFF_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_LAST     = DEB_W'(DEBOUNCE - 1);

  // State encoding is visible on the state port, so it is fixed here.
  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CHECK   = 3'd2,
    ST_RUN     = 3'd3,
    ST_BACKOFF = 3'd4,
    ST_LOCKOUT = 3'd5,
    ST_TEST    = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;       // settle / check-timeout / backoff window
  logic [DEB_W-1:0] deb_q, deb_d;       // consecutive qualifying ok_s samples
  logic [1:0]       retry_q, retry_d;   // failed attempts, saturating at 3
  logic             ok_meta_q, ok_meta_d;
  logic             ok_s_q, ok_s_d;
  logic             enable_q, enable_d;
  logic             ten_q, ten_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             fail;
  logic [1:0]       retry_inc;

  // Two-flop synchroniser input for the asynchronous ok status.
  always_comb begin
    ok_meta_d = bus.ok_currentmirror;
    ok_s_d    = ok_meta_q;
  end

  // Synchroniser flops; cleared by reset so a stale ok cannot qualify.
  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      ok_meta_q <= 1'b0;
      ok_s_q    <= 1'b0;
    end else begin
      ok_meta_q <= ok_meta_d;
      ok_s_q    <= ok_s_d;
    end
  end

  // Saturating increment used when an attempt fails.
  always_comb begin
    retry_inc = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
  end

  // Next-state, counter and retry logic. Priority: req low, then
  // test_mode, then clr_fault (LOCKOUT only), then normal sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    retry_d = retry_q;
    fail    = 1'b0;

    if (!bus.req) begin
      state_d = ST_OFF;
    end else if (bus.test_mode) begin
      state_d = ST_TEST;
    end else if (bus.clr_fault && (state_q == ST_LOCKOUT)) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_SETTLE;
        end

        // ok_s is deliberately ignored while the mirror settles.
        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = ST_CHECK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        // Qualification wins over a timeout landing on the same edge.
        ST_CHECK: begin
          if (ok_s_q) begin
            if (deb_q == DEB_LAST) begin
              state_d = ST_RUN;
            end else begin
              deb_d = deb_q + 1'b1;
            end
          end else begin
            deb_d = '0;
          end
          if (state_d != ST_RUN) begin
            if (cnt_q == SETTLE_LAST) begin
              fail = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end

        // Only a full DEBOUNCE run of low samples counts as a dropout.
        ST_RUN: begin
          if (!ok_s_q) begin
            if (deb_q == DEB_LAST) begin
              fail = 1'b1;
            end else begin
              deb_d = deb_q + 1'b1;
            end
          end else begin
            deb_d = '0;
          end
        end

        ST_BACKOFF: begin
          if (cnt_q == BACKOFF_LAST) begin
            state_d = ST_SETTLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_LOCKOUT: begin
          state_d = ST_LOCKOUT;
        end

        // Reached only with test_mode low: leave through OFF so the
        // mirror is fully re-sequenced.
        ST_TEST: begin
          state_d = ST_OFF;
        end

        default: begin
          state_d = ST_OFF;
        end
      endcase
    end

    if (fail) begin
      retry_d = retry_inc;
      state_d = (int'(retry_inc) < RETRY_MAX) ? ST_BACKOFF : ST_LOCKOUT;
    end

    // Every state entry starts its windows from zero.
    if (state_d != state_q) begin
      cnt_d = '0;
      deb_d = '0;
    end

    // OFF clears the attempt history; a qualified RUN forgives it.
    if ((state_d == ST_OFF) || (state_d == ST_RUN)) begin
      retry_d = '0;
    end
  end

  // Output decode from the next state so the registered outputs move on
  // the same edge as the state they describe.
  always_comb begin
    enable_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK) ||
               (state_d == ST_RUN)    || (state_d == ST_TEST);
    ten_d    = (state_d == ST_TEST);
    ready_d  = (state_d == ST_RUN) || ((state_d == ST_TEST) && ok_s_q);
    fault_d  = (state_d == ST_LOCKOUT);
  end

  // State, counters and output registers.
  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      deb_q    <= '0;
      retry_q  <= '0;
      enable_q <= 1'b0;
      ten_q    <= 1'b0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      deb_q    <= deb_d;
      retry_q  <= retry_d;
      enable_q <= enable_d;
      ten_q    <= ten_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.enable_currentmirror = enable_q;
  assign bus.ten                  = ten_q;
  assign bus.mirror_ready         = ready_q;
  assign bus.fault                = fault_q;
  assign bus.retry_cnt            = retry_q;
  assign bus.state                = state_q;

endmodule

// File: tb/tb_currentmirror_enable_sequencer.sv
// Self-checking bench for currentmirror_enable_sequencer: a phase/age
// model built from the behavioural rules feeds an expected queue that is
// compared against the DUT every cycle; literal pins fix key instants.
module tb_currentmirror_enable_sequencer;

  localparam int SETTLE = 64;
  localparam int DEB    = 4;
  localparam int RMAX   = 3;
  localparam int BACK   = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  currentmirror_enable_sequencer_if bus();

  currentmirror_enable_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .DEBOUNCE      (DEB),
    .RETRY_MAX     (RMAX),
    .BACKOFF_CYCLES(BACK),
    .CNT_W         (9)
  ) dut (
    .CELCLK(clk),
    .CELRST(rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- behavioural model ----------------
  // phase codes: 0 OFF, 1 SETTLE, 2 CHECK, 3 RUN, 4 BACKOFF, 5 LOCKOUT, 6 TEST
  int   m_phase = 0;
  int   m_age   = 0;      // edges spent in the phase since entry
  int   m_retry = 0;
  bit   m_tready = 1'b0;  // ok_s as registered in TEST
  bit   syn0 = 1'b0, syn1 = 1'b0;
  bit   hist[$];          // ok_s samples seen in the current phase
  bit   model_live = 1'b0;
  logic [8:0] exp_q[$];   // {state, retry, enable, ten, ready, fault}

  function automatic bit tail_all(bit v);
    if (hist.size() < DEB) return 1'b0;
    for (int i = 0; i < DEB; i++)
      if (hist[hist.size() - 1 - i] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_go(int p);
    if (p != m_phase) begin
      m_phase = p;
      m_age   = 0;
      hist.delete();
    end
    if (p == 0 || p == 3) m_retry = 0;
  endtask

  task automatic m_fail();
    m_retry = (m_retry < 3) ? m_retry + 1 : 3;
    m_go((m_retry < RMAX) ? 4 : 5);
  endtask

  function automatic logic [8:0] m_outputs();
    logic en, tn, rd, ft;
    en = (m_phase == 1) || (m_phase == 2) || (m_phase == 3) || (m_phase == 6);
    tn = (m_phase == 6);
    rd = (m_phase == 3) || ((m_phase == 6) && m_tready);
    ft = (m_phase == 5);
    return {3'(m_phase), 2'(m_retry), en, tn, rd, ft};
  endfunction

  // Model advance on every rising edge, then queue the expected outputs.
  always @(posedge clk) begin
    bit oks;
    oks = syn1;
    if (rst) begin
      syn0 = 1'b0;
      syn1 = 1'b0;
      m_go(0);
      m_retry    = 0;
      m_tready   = 1'b0;
      model_live = 1'b1;
    end else begin
      syn1     = syn0;
      syn0     = bus.ok_currentmirror;
      m_tready = oks;
      m_age++;
      if (!bus.req) m_go(0);
      else if (bus.test_mode) m_go(6);
      else if (bus.clr_fault && m_phase == 5) m_go(0);
      else begin
        case (m_phase)
          0: m_go(1);
          1: if (m_age == SETTLE) m_go(2);
          2: begin
            hist.push_back(oks);
            if (tail_all(1'b1)) m_go(3);
            else if (m_age == SETTLE) m_fail();
          end
          3: begin
            hist.push_back(oks);
            if (hist.size() > DEB) void'(hist.pop_front());
            if (tail_all(1'b0)) m_fail();
          end
          4: if (m_age == BACK) m_go(1);
          6: m_go(0);
          default: ;
        endcase
      end
    end
    if (model_live) exp_q.push_back(m_outputs());
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [8:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.state, bus.retry_cnt, bus.enable_currentmirror, bus.ten,
           bus.mirror_ready, bus.fault};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t actual={st,rty,en,ten,rdy,flt}=%b required=%b",
                 $time, a, e);
      end
    end
  end

  // ---------------- driver / literal checks ----------------
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic pin(string nm, int st, int en, int rdy, int flt, int rty);
    chk({nm, ".state"}, int'(bus.state), st);
    chk({nm, ".enable"}, int'(bus.enable_currentmirror), en);
    chk({nm, ".ready"}, int'(bus.mirror_ready), rdy);
    chk({nm, ".fault"}, int'(bus.fault), flt);
    chk({nm, ".retry"}, int'(bus.retry_cnt), rty);
    chk({nm, ".model_phase"}, m_phase, st);
  endtask

  initial begin
    bus.req              = 1'b0;
    bus.test_mode        = 1'b0;
    bus.clr_fault        = 1'b0;
    bus.ok_currentmirror = 1'b0;
    rst                  = 1'b1;
    tick(3);
    pin("reset", 0, 0, 0, 0, 0);
    chk("reset.ten", int'(bus.ten), 0);
    rst = 1'b0;

    // Nominal bring-up: SETTLE 64 edges, CHECK 4 edges, then RUN.
    bus.ok_currentmirror = 1'b1;
    tick(3);
    bus.req = 1'b1;
    tick(1);   pin("bring.settle_first", 1, 1, 0, 0, 0);
    tick(63);  pin("bring.settle_last", 1, 1, 0, 0, 0);
    tick(1);   pin("bring.check_first", 2, 1, 0, 0, 0);
    tick(3);   pin("bring.check_last", 2, 1, 0, 0, 0);
    tick(1);   pin("bring.run", 3, 1, 1, 0, 0);

    // Glitch rejection: 3 low samples ignored, 6 low samples fail.
    bus.ok_currentmirror = 1'b0; tick(3);
    bus.ok_currentmirror = 1'b1; tick(10);
    pin("glitch.short", 3, 1, 1, 0, 0);
    bus.ok_currentmirror = 1'b0; tick(6);
    bus.ok_currentmirror = 1'b1; tick(10);
    pin("glitch.long", 4, 0, 0, 0, 1);
    tick(340);
    pin("glitch.recover", 3, 1, 1, 0, 0);

    // Request withdrawal mid-SETTLE.
    bus.req = 1'b0; tick(1); pin("wd.off", 0, 0, 0, 0, 0);
    bus.req = 1'b1; tick(10); pin("wd.in_settle", 1, 1, 0, 0, 0);
    bus.req = 1'b0; tick(1); pin("wd.settle_drop", 0, 0, 0, 0, 0);

    // Request withdrawal mid-BACKOFF.
    bus.req = 1'b1; tick(70); pin("wd.run", 3, 1, 1, 0, 0);
    bus.ok_currentmirror = 1'b0; tick(10);
    pin("wd.backoff", 4, 0, 0, 0, 1);
    bus.req = 1'b0; tick(1); pin("wd.backoff_drop", 0, 0, 0, 0, 0);

    // req drop on the same edge the RUN dropout would qualify.
    bus.ok_currentmirror = 1'b1; bus.req = 1'b1; tick(75);
    pin("wd.run2", 3, 1, 1, 0, 0);
    bus.ok_currentmirror = 1'b0; tick(5);
    pin("wd.run_pending", 3, 1, 1, 0, 0);
    bus.req = 1'b0; tick(1);
    pin("wd.same_edge", 0, 0, 0, 0, 0);

    // Lockout: three CHECK timeouts with two backoffs in between.
    bus.req = 1'b1;
    tick(1);   pin("lock.settle", 1, 1, 0, 0, 0);
    tick(127); pin("lock.check1_end", 2, 1, 0, 0, 0);
    tick(1);   pin("lock.backoff1", 4, 0, 0, 0, 1);
    tick(767); pin("lock.check3_end", 2, 1, 0, 0, 2);
    tick(1);   pin("lock.locked", 5, 0, 0, 1, 3);

    // Lockout clear.
    bus.ok_currentmirror = 1'b1; tick(3);
    pin("lock.hold", 5, 0, 0, 1, 3);
    bus.clr_fault = 1'b1; tick(1); bus.clr_fault = 1'b0;
    pin("clr.off", 0, 0, 0, 0, 0);
    tick(1);  pin("clr.settle", 1, 1, 0, 0, 0);
    tick(67); pin("clr.check", 2, 1, 0, 0, 0);
    tick(1);  pin("clr.run", 3, 1, 1, 0, 0);
    bus.clr_fault = 1'b1; tick(1); bus.clr_fault = 1'b0;
    pin("clr.ignored_in_run", 3, 1, 1, 0, 0);

    // Test mode: ready follows ok with 3 edges of latency.
    bus.req = 1'b0; bus.ok_currentmirror = 1'b0; tick(3);
    bus.test_mode = 1'b1; bus.req = 1'b1; tick(1);
    pin("test.enter", 6, 1, 0, 0, 0);
    chk("test.ten", int'(bus.ten), 1);
    bus.ok_currentmirror = 1'b1; tick(2);
    chk("test.ready_lat2", int'(bus.mirror_ready), 0);
    tick(1);
    chk("test.ready_lat3", int'(bus.mirror_ready), 1);
    bus.test_mode = 1'b0; tick(1);
    pin("test.exit", 0, 0, 0, 0, 0);
    tick(1);
    pin("test.resequence", 1, 1, 0, 0, 0);

    // Reset during RUN.
    tick(70); pin("rst.run", 3, 1, 1, 0, 0);
    rst = 1'b1; tick(1);
    pin("rst.mid_run", 0, 0, 0, 0, 0);
    chk("rst.ten", int'(bus.ten), 0);
    rst = 1'b0; tick(1);
    pin("rst.after", 1, 1, 0, 0, 0);
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
